// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, flag bit positions and FSM states shared by the ALU files
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_ASH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the controller and alu_seq
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] Rsrc;
  logic [WIDTH-1:0] Rdes;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  logic             busy;
  logic             done;
  modport master (output start, op, Rsrc, Rdes, input result, flags, busy, done);
  modport slave  (input start, op, Rsrc, Rdes, output result, flags, busy, done);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle after load
module alu_mul_iter #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // product is the accumulator after the current iteration, so the caller can capture it on the last edge
  always_comb begin
    acc_d   = load ? '0 : acc_q + (b_q[0] ? a_q : '0);
    a_d     = load ? a : a_q << 1;
    b_d     = load ? b : b_q >> 1;
    cnt_d   = load ? '0 : cnt_q + 1'b1;
    product = acc_d;
    last    = cnt_q == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU ops plus iterative multiply behind a start/done handshake
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, product, lsh, asr, ash;
  logic [4:0]       flags_q, flags_d;
  logic             done_q, done_d, load, mul_last, ovf_add, ovf_sub, writes, arith;
  logic [WIDTH:0]   sum, diff;
  logic [SHW+1:0]   amt, mag;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .load(load), .a(bus.Rdes), .b(bus.Rsrc),
    .product(product), .last(mul_last)
  );
  assign sum     = {1'b0, bus.Rdes} + {1'b0, bus.Rsrc};
  assign diff    = {1'b0, bus.Rdes} - {1'b0, bus.Rsrc};
  assign ovf_add = (bus.Rdes[WIDTH-1] == bus.Rsrc[WIDTH-1]) && (sum[WIDTH-1] != bus.Rdes[WIDTH-1]);
  assign ovf_sub = (bus.Rdes[WIDTH-1] != bus.Rsrc[WIDTH-1]) && (diff[WIDTH-1] != bus.Rdes[WIDTH-1]);
  // sign-extended shift amount and its magnitude; -(-WIDTH) needs the extra bit
  assign amt     = {bus.Rsrc[SHW], bus.Rsrc[SHW:0]};
  assign mag     = amt[SHW+1] ? -amt : amt;
  assign asr     = $signed(bus.Rdes) >>> mag;
  assign lsh     = amt[SHW+1] ? bus.Rdes >> mag : bus.Rdes << mag;
  assign ash     = amt[SHW+1] ? asr : bus.Rdes << mag;
  assign alu_res = bus.op == OP_ADD ? sum[WIDTH-1:0] :
                   bus.op == OP_SUB ? diff[WIDTH-1:0] :
                   bus.op == OP_AND ? bus.Rdes & bus.Rsrc :
                   bus.op == OP_OR  ? bus.Rdes | bus.Rsrc :
                   bus.op == OP_XOR ? bus.Rdes ^ bus.Rsrc :
                   bus.op == OP_LSH ? lsh :
                   bus.op == OP_ASH ? ash : bus.Rsrc;
  assign writes  = bus.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ASH, OP_MOV};
  assign arith   = bus.op inside {OP_ADD, OP_SUB, OP_CMP};
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    load     = 1'b0;
    if (state_q == ST_MUL) begin
      if (mul_last) begin
        state_d         = ST_IDLE;
        done_d          = 1'b1;
        result_d        = product;
        flags_d[FLAG_Z] = product == '0;
        flags_d[FLAG_N] = product[WIDTH-1];
      end
    end else if (bus.start && bus.op == OP_MUL) begin
      state_d = ST_MUL;
      load    = 1'b1;
    end else if (bus.start) begin
      done_d = 1'b1;
      if (writes) begin
        result_d        = alu_res;
        flags_d[FLAG_Z] = alu_res == '0;
        flags_d[FLAG_N] = alu_res[WIDTH-1];
      end
      if (arith) begin
        flags_d[FLAG_C] = bus.op == OP_ADD ? sum[WIDTH] : diff[WIDTH];
        flags_d[FLAG_F] = bus.op == OP_ADD ? ovf_add : ovf_sub;
      end
      if (bus.op == OP_SUB || bus.op == OP_CMP) flags_d[FLAG_L] = diff[WIDTH];
      if (bus.op == OP_CMP) begin
        flags_d[FLAG_Z] = bus.Rdes == bus.Rsrc;
        flags_d[FLAG_N] = $signed(bus.Rdes) < $signed(bus.Rsrc);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.done   = done_q;
  assign bus.busy   = state_q == ST_MUL;
endmodule
